instruction_encoder: RTL and testbench

Sequential RV32 instruction encoder and instruction-memory loader; the encode side of the processor's instruction decode path. Accepts symbolic operation requests (operation, rd, rs1, rs2, immediate) over a valid/ready handshake. Packs each request into a 32-bit RISC-V word and writes it to consecutive instruction-memory words starting at address 0. Used by test harnesses and the boot loader to build programs that the processor then fetches and decodes.

---
 rtl/instruction_encoder.sv | 200 ++++++++++++++++++++
 tb/tb_instruction_encoder.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/instruction_encoder.sv
// Purpose: packs symbolic RV32 requests (LW/SW/ADD/SUB/ADDI) into 32-bit words and
//          writes them to consecutive instruction-memory words starting at address 0.
// Ports:   clk/rst (async active-high); req_* valid/ready request channel; flush restart;
//          im_* instruction-memory write/read port; count/full/err_illegal/err_verify status.
// Latency: accept at edge N -> write strobe in cycle N+1; req_ready low for 1 cycle
//          (3 cycles when readback verification is built in).
// Backpressure: req_ready is high only in IDLE; once DEPTH words are written the block
//          holds req_ready low until flush or rst.
// Option:  define ENCODER_READBACK_EN to read back and verify every written word.
module instruction_encoder #(
    parameter int INSTRUCTION_SIZE = 32,
    parameter int ADDR_WIDTH       = 8,
    parameter int DEPTH            = 256
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        req_valid,
    output logic                        req_ready,
    input  logic [2:0]                  req_op,
    input  logic [4:0]                  req_rd,
    input  logic [4:0]                  req_rs1,
    input  logic [4:0]                  req_rs2,
    input  logic [11:0]                 req_imm,
    input  logic                        flush,
    output logic                        im_write_en,
    output logic [ADDR_WIDTH-1:0]       im_addr,
    output logic [INSTRUCTION_SIZE-1:0] im_write_data,
    input  logic [INSTRUCTION_SIZE-1:0] im_read_data,
    output logic [ADDR_WIDTH:0]         count,
    output logic                        full,
    output logic                        err_illegal,
    output logic                        err_verify
);

    localparam logic [2:0] OP_LW   = 3'd0;
    localparam logic [2:0] OP_SW   = 3'd1;
    localparam logic [2:0] OP_ADD  = 3'd2;
    localparam logic [2:0] OP_SUB  = 3'd3;
    localparam logic [2:0] OP_ADDI = 3'd4;

    localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH+1)'(DEPTH);

`ifdef ENCODER_READBACK_EN
    typedef enum logic [2:0] {IDLE, WRITE, READ, CHECK, FULL} state_t;
`else
    typedef enum logic [2:0] {IDLE, WRITE, FULL} state_t;
`endif

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic [2:0]            op_q, op_d;
    logic [4:0]            rd_q, rd_d;
    logic [4:0]            rs1_q, rs1_d;
    logic [4:0]            rs2_q, rs2_d;
    logic [11:0]           imm_q, imm_d;
    logic                  err_illegal_q, err_illegal_d;
`ifdef ENCODER_READBACK_EN
    logic                  err_verify_q, err_verify_d;
`else
    wire                   unused_read_data = ^im_read_data;
`endif

    logic [INSTRUCTION_SIZE-1:0] word;
    logic                        accept;
    logic [ADDR_WIDTH:0]         count_inc;

    // Encode from the captured fields so the word is stable for WRITE and CHECK.
    always_comb begin
        word = '0;
        case (op_q)
            OP_LW:   word = {imm_q, rs1_q, 3'b010, rd_q, 7'b0000011};
            OP_SW:   word = {imm_q[11:5], rs2_q, rs1_q, 3'b010, imm_q[4:0], 7'b0100011};
            OP_ADD:  word = {7'b0000000, rs2_q, rs1_q, 3'b000, rd_q, 7'b0110011};
            OP_SUB:  word = {7'b0100000, rs2_q, rs1_q, 3'b000, rd_q, 7'b0110011};
            OP_ADDI: word = {imm_q, rs1_q, 3'b000, rd_q, 7'b0010011};
            default: word = '0;
        endcase
    end

    // Gated by rst so the channel reads not-ready while reset is held.
    assign req_ready = (state_q == IDLE) && !rst;
    assign accept    = req_valid && req_ready;
    assign count_inc = count_q + 1'b1;

    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        count_d       = count_q;
        op_d          = op_q;
        rd_d          = rd_q;
        rs1_d         = rs1_q;
        rs2_d         = rs2_q;
        imm_d         = imm_q;
        err_illegal_d = err_illegal_q;
`ifdef ENCODER_READBACK_EN
        err_verify_d  = err_verify_q;
`endif

        case (state_q)
            IDLE: begin
                if (accept) begin
                    op_d  = req_op;
                    rd_d  = req_rd;
                    rs1_d = req_rs1;
                    rs2_d = req_rs2;
                    imm_d = req_imm;
                    if (req_op <= OP_ADDI) begin
                        state_d = WRITE;
                    end else begin
                        err_illegal_d = 1'b1;
                    end
                end
            end
`ifdef ENCODER_READBACK_EN
            WRITE: state_d = READ;
            READ:  state_d = CHECK;
            CHECK: begin
                if (im_read_data != word) begin
                    err_verify_d = 1'b1;
                end
                count_d = count_inc;
                // Pointer stays on the last word once full instead of wrapping.
                if (count_inc == DEPTH_C) begin
                    state_d = FULL;
                end else begin
                    addr_d  = addr_q + 1'b1;
                    state_d = IDLE;
                end
            end
`else
            WRITE: begin
                count_d = count_inc;
                if (count_inc == DEPTH_C) begin
                    state_d = FULL;
                end else begin
                    addr_d  = addr_q + 1'b1;
                    state_d = IDLE;
                end
            end
`endif
            FULL:    state_d = FULL;
            default: state_d = IDLE;
        endcase

        // flush overrides everything, including an accept in the same cycle.
        if (flush) begin
            state_d       = IDLE;
            addr_d        = '0;
            count_d       = '0;
            err_illegal_d = 1'b0;
`ifdef ENCODER_READBACK_EN
            err_verify_d  = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            addr_q        <= '0;
            count_q       <= '0;
            op_q          <= '0;
            rd_q          <= '0;
            rs1_q         <= '0;
            rs2_q         <= '0;
            imm_q         <= '0;
            err_illegal_q <= 1'b0;
`ifdef ENCODER_READBACK_EN
            err_verify_q  <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            count_q       <= count_d;
            op_q          <= op_d;
            rd_q          <= rd_d;
            rs1_q         <= rs1_d;
            rs2_q         <= rs2_d;
            imm_q         <= imm_d;
            err_illegal_q <= err_illegal_d;
`ifdef ENCODER_READBACK_EN
            err_verify_q  <= err_verify_d;
`endif
        end
    end

    assign im_write_en   = (state_q == WRITE);
    assign im_addr       = addr_q;
    assign im_write_data = (state_q == WRITE) ? word : '0;
    assign count         = count_q;
    assign full          = (state_q == FULL);
    assign err_illegal   = err_illegal_q;
`ifdef ENCODER_READBACK_EN
    assign err_verify    = err_verify_q;
`else
    assign err_verify    = 1'b0;
`endif

endmodule

// File: tb/tb_instruction_encoder.sv
module tb_instruction_encoder;

    localparam int AW    = 8;
    localparam int DEPTH = 4;
`ifdef ENCODER_READBACK_EN
    localparam int GAP = 3;
`else
    localparam int GAP = 1;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [2:0]    req_op = '0;
    logic [4:0]    req_rd = '0;
    logic [4:0]    req_rs1 = '0;
    logic [4:0]    req_rs2 = '0;
    logic [11:0]   req_imm = '0;
    logic          flush = 1'b0;
    logic          im_write_en;
    logic [AW-1:0] im_addr;
    logic [31:0]   im_write_data;
    logic [31:0]   im_read_data = '0;
    logic [AW:0]   count;
    logic          full;
    logic          err_illegal;
    logic          err_verify;

    instruction_encoder #(.INSTRUCTION_SIZE(32), .ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_rd(req_rd), .req_rs1(req_rs1), .req_rs2(req_rs2),
        .req_imm(req_imm), .flush(flush),
        .im_write_en(im_write_en), .im_addr(im_addr), .im_write_data(im_write_data),
        .im_read_data(im_read_data), .count(count), .full(full),
        .err_illegal(err_illegal), .err_verify(err_verify)
    );

    always #5 clk = ~clk;

    // Memory model: registered read, optional corruption of the returned word.
    logic [31:0] mem [0:255];
    logic        corrupt = 1'b0;
    int          wr_cnt = 0;
    always @(posedge clk) begin
        if (im_write_en) begin
            mem[im_addr] <= im_write_data;
            wr_cnt       <= wr_cnt + 1;
        end else begin
            im_read_data <= mem[im_addr] ^ (corrupt ? 32'h0000_0100 : 32'h0);
        end
    end

    int passed = 0;
    int total  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    // Waits (bounded) for req_ready, presents one request for exactly one edge.
    task automatic send(input logic [2:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [11:0] imm);
        int n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) check("ready_timeout", 32'(req_ready), 32'd1);
        req_op = op; req_rd = rd; req_rs1 = rs1; req_rs2 = rs2; req_imm = imm;
        req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic do_flush();
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        @(negedge clk);
    endtask

    typedef struct {
        logic [2:0]  op;
        logic [4:0]  rd, rs1, rs2;
        logic [11:0] imm;
        logic [31:0] exp_word;
        logic [AW-1:0] exp_addr;
        logic        exp_full;
        string       name;
    } vec_t;

    vec_t vecs [5];

    initial begin
        int g;
        int saved;

        vecs[0] = '{3'd2, 5'd3, 5'd1, 5'd2, 12'h000, 32'h002081B3, 8'd0, 1'b0, "add"};
        vecs[1] = '{3'd3, 5'd3, 5'd1, 5'd2, 12'h000, 32'h402081B3, 8'd0, 1'b0, "sub"};
        vecs[2] = '{3'd4, 5'd5, 5'd0, 5'd0, 12'hFFF, 32'hFFF00293, 8'd1, 1'b0, "addi"};
        vecs[3] = '{3'd0, 5'd6, 5'd2, 5'd0, 12'd8,   32'h00812303, 8'd2, 1'b0, "lw"};
        vecs[4] = '{3'd1, 5'd0, 5'd2, 5'd7, 12'd12,  32'h00712623, 8'd3, 1'b1, "sw"};

        // Reset values while rst is held.
        repeat (3) @(negedge clk);
        check("rst_ready", 32'(req_ready), 32'd0);
        check("rst_we", 32'(im_write_en), 32'd0);
        check("rst_addr", 32'(im_addr), 32'd0);
        check("rst_wdata", im_write_data, 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_flags", {28'd0, full, err_illegal, err_verify, 1'b0}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_rst", 32'(req_ready), 32'd1);

        // Vectors: ADD alone, flush, then four back-to-back filling DEPTH=4.
        for (int i = 0; i < 5; i++) begin
            send(vecs[i].op, vecs[i].rd, vecs[i].rs1, vecs[i].rs2, vecs[i].imm);
            @(negedge clk);
            check({vecs[i].name, "_we"}, 32'(im_write_en), 32'd1);
            check({vecs[i].name, "_addr"}, 32'(im_addr), 32'(vecs[i].exp_addr));
            check({vecs[i].name, "_word"}, im_write_data, vecs[i].exp_word);
            check({vecs[i].name, "_ready_low"}, 32'(req_ready), 32'd0);
            if (vecs[i].exp_full) begin
                repeat (GAP) @(negedge clk);
                check("full_flag", 32'(full), 32'd1);
                check("full_ready", 32'(req_ready), 32'd0);
            end else begin
                g = 1;
                @(negedge clk);
                check({vecs[i].name, "_we_one_cycle"}, 32'(im_write_en), 32'd0);
                while (!req_ready && g < 10) begin
                    @(negedge clk);
                    g++;
                end
                check({vecs[i].name, "_gap"}, 32'(g), 32'(GAP));
            end
            check({vecs[i].name, "_count"}, 32'(count), 32'(vecs[i].exp_addr) + 32'd1);
            if (i == 0) do_flush();
        end

        // A request while full produces no write.
        saved = wr_cnt;
        req_valid = 1'b1;
        repeat (3) @(negedge clk);
        req_valid = 1'b0;
        check("full_no_write", 32'(wr_cnt), 32'(saved));
        check("full_count", 32'(count), 32'd4);
        do_flush();
        check("flush_addr", 32'(im_addr), 32'd0);
        check("flush_count", 32'(count), 32'd0);
        check("flush_ready", 32'(req_ready), 32'd1);
        check("flush_full", 32'(full), 32'd0);

        // Illegal op.
        saved = wr_cnt;
        send(3'd6, 5'd1, 5'd1, 5'd1, 12'd0);
        @(negedge clk);
        check("ill_we", 32'(im_write_en), 32'd0);
        check("ill_err", 32'(err_illegal), 32'd1);
        check("ill_count", 32'(count), 32'd0);
        check("ill_ready", 32'(req_ready), 32'd1);
        @(negedge clk);
        check("ill_no_write", 32'(wr_cnt), 32'(saved));
        do_flush();
        check("ill_cleared", 32'(err_illegal), 32'd0);

`ifdef ENCODER_READBACK_EN
        // Corrupted readback: WRITE, READ, CHECK, then err_verify visible.
        corrupt = 1'b1;
        send(3'd2, 5'd3, 5'd1, 5'd2, 12'd0);
        repeat (4) @(negedge clk);
        check("verify_err", 32'(err_verify), 32'd1);
        check("verify_count", 32'(count), 32'd1);
        corrupt = 1'b0;
        do_flush();
        check("verify_cleared", 32'(err_verify), 32'd0);
`else
        check("verify_tied", 32'(err_verify), 32'd0);
`endif

        // rst during WRITE discards the pending word.
        send(3'd2, 5'd3, 5'd1, 5'd2, 12'd0);
        repeat (GAP + 1) @(negedge clk);
        check("pre_rst_count", 32'(count), 32'd1);
        saved = wr_cnt;
        send(3'd4, 5'd5, 5'd0, 5'd0, 12'hFFF);
        @(negedge clk);
        check("pre_rst_we", 32'(im_write_en), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_we", 32'(im_write_en), 32'd0);
        check("mid_rst_count", 32'(count), 32'd0);
        check("mid_rst_ready", 32'(req_ready), 32'd0);
        check("mid_rst_wdata", im_write_data, 32'd0);
        check("mid_rst_no_write", 32'(wr_cnt), 32'(saved));
        rst = 1'b0;
        @(negedge clk);
        send(3'd3, 5'd3, 5'd1, 5'd2, 12'd0);
        @(negedge clk);
        check("post_rst_addr", 32'(im_addr), 32'd0);
        check("post_rst_word", im_write_data, 32'h402081B3);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
